crc_result_collector: RTL and testbench
=======================================

CRC_RESULT_COLLECTOR -- requirements
Module: crc_result_collector

Interface
REQ-001 The block SHALL have parameter P_WIDTH, default 8, giving the CRC width in bits.
REQ-002 The block SHALL have parameter P_POLYNOM, default 8'h31, giving the generator polynomial without its implicit top bit.
REQ-003 The block SHALL have parameter P_XOR_OUT, default 0, giving the final XOR mask.
REQ-004 The block SHALL have parameter P_LATENCY, default 32, giving the number of CRC stages upstream (>=1).
REQ-005 The block SHALL have parameter P_DEPTH, default 4, giving the result FIFO depth (power of 2, >=2).
REQ-006 The block SHALL have parameter P_ID_W, default 4, giving the message tag width.
REQ-007 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-008 The block SHALL have port rst, input, 1 bit: asynchronous active-high reset.
REQ-009 The block SHALL have port msg_end, input, 1 bit: the last message bit enters stage 0 this cycle.
REQ-010 The block SHALL have port msg_id, input, P_ID_W bits: tag for the message ending this cycle.
REQ-011 The block SHALL have port in_ready, output, 1 bit: credit available; msg_end is accepted only when in_ready=1.
REQ-012 The block SHALL have port stage_data, input, P_WIDTH bits: next_data of the last CRC stage.
REQ-013 The block SHALL have port stage_sign, input, 1 bit: next_sign of the last CRC stage.
REQ-014 The block SHALL have port out_valid, output, 1 bit: a result is presented.
REQ-015 The block SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-016 The block SHALL have port out_crc, output, P_WIDTH bits: the final CRC.
REQ-017 The block SHALL have port out_id, output, P_ID_W bits: the tag of out_crc.
REQ-018 The block SHALL have port overflow, output, 1 bit: sticky error flag.

Function
REQ-019 Accept SHALL occur when msg_end=1 and in_ready=1; msg_end with in_ready=0 SHALL be ignored and not counted.
REQ-020 An accepted {msg_id} SHALL traverse a P_LATENCY-deep tag shift register (valid bit plus id), emerging exactly P_LATENCY cycles after accept.
REQ-021 On the emerge cycle the block SHALL capture result = (stage_sign ? stage_data ^ P_POLYNOM : stage_data) ^ P_XOR_OUT together with its id into the FIFO.
REQ-022 The push-to-out_valid latency SHALL be 1 cycle when the FIFO is empty, giving an accept-to-out_valid latency of P_LATENCY+1.
REQ-023 A pop SHALL occur when out_valid=1 and out_ready=1; out_crc and out_id SHALL hold stable while out_valid=1 and out_ready=0.
REQ-024 Counter inflight (0..P_DEPTH) SHALL increment on accept, decrement on emerge, and stay unchanged when both occur in the same cycle.
REQ-025 Signal in_ready SHALL equal (inflight + fifo_count) < P_DEPTH, as a registered-state function with no combinational path from msg_end.
REQ-026 Push and pop in the same cycle SHALL both take effect, including when the FIFO is full (count unchanged) or empty; data SHALL NOT pass through combinationally.
REQ-027 The FIFO read and write pointers SHALL wrap modulo P_DEPTH; full and empty SHALL be distinguished by an extra pointer bit or by the count.
REQ-028 A push while the FIFO is full and no pop occurs SHALL drop the result, leave FIFO contents unchanged, and set overflow=1 until reset.
REQ-029 stage_data and stage_sign SHALL be ignored on cycles with no emerging tag.

Reset
REQ-030 While rst=1, out_valid, out_crc, out_id, overflow, inflight, the FIFO pointers and the tag valid bits SHALL be 0.
REQ-031 in_ready SHALL be 1 from the first cycle after rst deasserts.
REQ-032 Reset mid-operation SHALL discard all in-flight tags and buffered results; no result from before reset SHALL ever appear.

Structure
REQ-033 Package crc_pkg SHALL hold the default width and polynomial constants and the crc_result_t struct {crc, id}.
REQ-034 The FIFO SHALL be the sub-module crc_result_fifo, parameterised by depth and element type; tag pipeline, credit counter and final reduction SHALL live in crc_result_collector.

Verification
REQ-035 The bench SHALL cover: P_LATENCY=4, accept at cycle 10 with id=3, stage_sign=1, stage_data=8'hA5 at cycle 14 -> out_valid at cycle 15, out_crc=8'h94, out_id=3.
REQ-036 The bench SHALL cover: out_ready held 0 and P_DEPTH+2 msg_end pulses -> exactly 4 accepted, in_ready=0 thereafter, overflow stays 0.
REQ-037 The bench SHALL cover: FIFO full plus simultaneous pop and push -> count stays 4, order preserved, in_ready stays 0.
REQ-038 The bench SHALL cover: back-to-back accepts with id 0..7 and out_ready=1 -> 8 results in order at 1 per cycle, inflight returns to 0.
REQ-039 The bench SHALL cover: forced emerge with a full FIFO (credit check bypassed by force) -> result dropped, overflow=1 until rst.
REQ-040 The bench SHALL cover: rst asserted asynchronously with 2 tags in flight and 1 buffered -> out_valid=0 immediately, no stale result after release.

Source files
------------

// File: rtl/crc_pkg.sv
// Shared defaults and result record for the CRC result collector.
package crc_pkg;

  localparam int unsigned CRC_WIDTH = 8;
  localparam int unsigned CRC_ID_W  = 4;
  localparam logic [CRC_WIDTH-1:0] CRC_POLYNOM = 8'h31;

  typedef struct packed {
    logic [CRC_WIDTH-1:0] crc;
    logic [CRC_ID_W-1:0]  id;
  } crc_result_t;

endpackage

// File: rtl/crc_result_fifo.sv
// Result FIFO with same-cycle push/pop at full and a drop indication on overflow.
module crc_result_fifo #(
  parameter int unsigned P_DEPTH = 4,
  parameter type         T       = logic
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  T                           push_data_i,
  input  logic                       pop_i,
  output logic                       valid_o,
  output T                           data_o,
  output logic [$clog2(P_DEPTH):0]   count_o,
  output logic                       drop_o
);

  localparam int unsigned Aw = $clog2(P_DEPTH);

  T           mem [P_DEPTH];
  logic [Aw:0] wptr_q, wptr_d;
  logic [Aw:0] rptr_q, rptr_d;
  logic        empty, full, pop_ok, push_ok;

  always_comb begin
    empty   = (wptr_q == rptr_q);
    // Extra MSB separates full from empty when the low bits match.
    full    = (wptr_q[Aw] != rptr_q[Aw]) && (wptr_q[Aw-1:0] == rptr_q[Aw-1:0]);
    pop_ok  = pop_i & ~empty;
    push_ok = push_i & (~full | pop_ok);
    drop_o  = push_i & full & ~pop_ok;
    wptr_d  = push_ok ? wptr_q + (Aw+1)'(1) : wptr_q;
    rptr_d  = pop_ok ? rptr_q + (Aw+1)'(1) : rptr_q;
    valid_o = ~empty;
    count_o = wptr_q - rptr_q;
    data_o  = empty ? T'('0) : mem[rptr_q[Aw-1:0]];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem[wptr_q[Aw-1:0]] <= push_data_i;
    end
  end

endmodule

// File: rtl/crc_result_collector.sv
// Tracks message tags through the CRC pipeline, finalises the CRC and buffers
// results behind a credit scheme sized to the result FIFO.
module crc_result_collector
  import crc_pkg::*;
#(
  parameter int unsigned          P_WIDTH   = CRC_WIDTH,
  parameter logic [P_WIDTH-1:0]   P_POLYNOM = P_WIDTH'(CRC_POLYNOM),
  parameter logic [P_WIDTH-1:0]   P_XOR_OUT = '0,
  parameter int unsigned          P_LATENCY = 32,
  parameter int unsigned          P_DEPTH   = 4,
  parameter int unsigned          P_ID_W    = CRC_ID_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               msg_end,
  input  logic [P_ID_W-1:0]  msg_id,
  output logic               in_ready,
  input  logic [P_WIDTH-1:0] stage_data,
  input  logic               stage_sign,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [P_WIDTH-1:0] out_crc,
  output logic [P_ID_W-1:0]  out_id,
  output logic               overflow
);

  localparam int unsigned CntW = $clog2(P_DEPTH) + 1;

  typedef struct packed {
    logic [P_WIDTH-1:0] crc;
    logic [P_ID_W-1:0]  id;
  } result_t;

  logic                 accept, emerge, pop, fifo_drop;
  logic [P_LATENCY-1:0] tag_vld_q, tag_vld_d;
  logic [P_ID_W-1:0]    tag_id_q [P_LATENCY];
  logic [P_ID_W-1:0]    tag_id_d [P_LATENCY];
  logic [CntW-1:0]      inflight_q, inflight_d;
  logic [CntW-1:0]      fifo_count;
  logic [CntW:0]        credit_used;
  logic                 overflow_q, overflow_d;
  result_t              push_data, head;

  assign accept = msg_end & in_ready;
  assign emerge = tag_vld_q[P_LATENCY-1];
  assign pop    = out_valid & out_ready;

  always_comb begin
    tag_vld_d    = tag_vld_q;
    tag_id_d     = tag_id_q;
    tag_vld_d[0] = accept;
    tag_id_d[0]  = msg_id;
    for (int i = 1; i < P_LATENCY; i++) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_id_d[i]  = tag_id_q[i-1];
    end
  end

  always_comb begin
    inflight_d = inflight_q;
    case ({accept, emerge})
      2'b10:   inflight_d = inflight_q + CntW'(1);
      2'b01:   inflight_d = inflight_q - CntW'(1);
      default: inflight_d = inflight_q;
    endcase
    // Credits cover both tags still in the pipe and results already buffered.
    credit_used = (CntW+1)'(inflight_q) + (CntW+1)'(fifo_count);
    in_ready    = credit_used < (CntW+1)'(P_DEPTH);
    overflow_d  = overflow_q | fifo_drop;
  end

  always_comb begin
    push_data.crc = (stage_sign ? (stage_data ^ P_POLYNOM) : stage_data) ^ P_XOR_OUT;
    push_data.id  = tag_id_q[P_LATENCY-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_vld_q  <= '0;
      tag_id_q   <= '{default: '0};
      inflight_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      tag_vld_q  <= tag_vld_d;
      tag_id_q   <= tag_id_d;
      inflight_q <= inflight_d;
      overflow_q <= overflow_d;
    end
  end

  crc_result_fifo #(
    .P_DEPTH (P_DEPTH),
    .T       (result_t)
  ) u_fifo (
    .clk_i       (clk),
    .rst_i       (rst),
    .push_i      (emerge),
    .push_data_i (push_data),
    .pop_i       (pop),
    .valid_o     (out_valid),
    .data_o      (head),
    .count_o     (fifo_count),
    .drop_o      (fifo_drop)
  );

  assign out_crc  = head.crc;
  assign out_id   = head.id;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_crc_result_collector.sv
// Directed bench for crc_result_collector with P_LATENCY=4, P_DEPTH=4.
module tb_crc_result_collector;
  import crc_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       msg_end;
  logic [3:0] msg_id;
  logic       in_ready;
  logic [7:0] stage_data;
  logic       stage_sign;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_crc;
  logic [3:0] out_id;
  logic       overflow;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit manual_stage = 0;
  crc_result_t exp_q[$];

  crc_result_collector #(
    .P_LATENCY (4),
    .P_DEPTH   (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .msg_end    (msg_end),
    .msg_id     (msg_id),
    .in_ready   (in_ready),
    .stage_data (stage_data),
    .stage_sign (stage_sign),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_crc    (out_crc),
    .out_id     (out_id),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  // Upstream stand-in: stage_data follows the cycle number, sign 0, so a message
  // accepted on cycle c finalises to (c+4) mod 256.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (!manual_stage) begin
      stage_data = cyc[7:0];
      stage_sign = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; msg_end = 1'b0; msg_id = '0; out_ready = 1'b0;
    stage_data = '0; stage_sign = 1'b0;
    #2;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", out_valid); end
    checks++; if (out_crc !== 8'h00) begin errors++; $display("FAIL reset_crc got=%h want=00", out_crc); end
    checks++; if (out_id !== 4'h0) begin errors++; $display("FAIL reset_id got=%h want=0", out_id); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b want=0", overflow); end
    step(); step();
    rst = 1'b0;
    step();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_latency();
    manual_stage = 1; stage_sign = 1'b1; stage_data = 8'hFF;
    msg_end = 1'b1; msg_id = 4'd3;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL lat_ready got=%b want=1", in_ready); end
    step();
    msg_end = 1'b0;
    for (int i = 1; i < 4; i++) begin
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lat_early_valid i=%0d got=%b want=0", i, out_valid); end
      step();
    end
    stage_data = 8'hA5; stage_sign = 1'b1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lat_emerge_valid got=%b want=0", out_valid); end
    step();
    stage_data = 8'hFF;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL lat_valid got=%b want=1", out_valid); end
    checks++; if (out_crc !== 8'h94) begin errors++; $display("FAIL lat_crc got=%h want=94", out_crc); end
    checks++; if (out_id !== 4'd3) begin errors++; $display("FAIL lat_id got=%0d want=3", out_id); end
    step();
    checks++; if (out_crc !== 8'h94 || out_id !== 4'd3) begin errors++; $display("FAIL lat_hold got=%h/%0d want=94/3", out_crc, out_id); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lat_pop got=%b want=0", out_valid); end
    manual_stage = 0;
  endtask

  task automatic test_fill();
    int accepted = 0;
    out_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      msg_end = 1'b1; msg_id = 4'(k);
      if (in_ready) begin
        accepted++;
        exp_q.push_back('{crc: 8'(cyc + 4), id: 4'(k)});
      end
      step();
    end
    msg_end = 1'b0;
    checks++; if (accepted != 4) begin errors++; $display("FAIL fill_accepts got=%0d want=4", accepted); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_ready got=%b want=0", in_ready); end
    repeat (6) step();
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fill_ovf got=%b want=0", overflow); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_ready_late got=%b want=0", in_ready); end
    checks++; if (dut.fifo_count !== 3'd4) begin errors++; $display("FAIL fill_count got=%0d want=4", dut.fifo_count); end
    checks++; if (out_id !== 4'd0 || out_crc !== exp_q[0].crc) begin
      errors++; $display("FAIL fill_head got=%h/%0d want=%h/0", out_crc, out_id, exp_q[0].crc);
    end
  endtask

  task automatic test_full_push_pop();
    crc_result_t e;
    msg_end = 1'b1; msg_id = 4'd9;
    force dut.accept = 1'b1;
    exp_q.push_back('{crc: 8'(cyc + 4), id: 4'd9});
    step();
    release dut.accept;
    msg_end = 1'b0;
    step(); step(); step();
    checks++; if (dut.fifo_count !== 3'd4) begin errors++; $display("FAIL fpp_pre_count got=%0d want=4", dut.fifo_count); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    void'(exp_q.pop_front());
    checks++; if (dut.fifo_count !== 3'd4) begin errors++; $display("FAIL fpp_count got=%0d want=4", dut.fifo_count); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fpp_ready got=%b want=0", in_ready); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fpp_ovf got=%b want=0", overflow); end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      e = exp_q.pop_front();
      checks++; if (out_valid !== 1'b1 || out_crc !== e.crc || out_id !== e.id) begin
        errors++; $display("FAIL fpp_order i=%0d got=%b/%h/%0d want=1/%h/%0d", i, out_valid, out_crc, out_id, e.crc, e.id);
      end
      step();
    end
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL fpp_drained got=%b/%b want=0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    int k = 0, got = 0, budget = 0;
    int pop_cyc[8];
    crc_result_t e;
    out_ready = 1'b1;
    while (got < 8 && budget < 100) begin
      if (out_valid) begin
        e = exp_q.pop_front();
        pop_cyc[got] = cyc;
        checks++; if (out_crc !== e.crc || out_id !== e.id) begin
          errors++; $display("FAIL b2b_result n=%0d got=%h/%0d want=%h/%0d", got, out_crc, out_id, e.crc, e.id);
        end
        got++;
      end
      if (k < 8) begin
        msg_end = 1'b1; msg_id = 4'(k);
        if (in_ready) begin
          exp_q.push_back('{crc: 8'(cyc + 4), id: 4'(k)});
          k++;
        end
      end else begin
        msg_end = 1'b0;
      end
      step();
      budget++;
    end
    msg_end = 1'b0;
    checks++; if (got != 8) begin errors++; $display("FAIL b2b_count got=%0d want=8", got); end
    checks++; if (pop_cyc[3] - pop_cyc[0] != 3) begin errors++; $display("FAIL b2b_rate got=%0d want=3", pop_cyc[3] - pop_cyc[0]); end
    checks++; if (dut.inflight_q !== 3'd0) begin errors++; $display("FAIL b2b_inflight got=%0d want=0", dut.inflight_q); end
    out_ready = 1'b0;
  endtask

  task automatic test_overflow();
    int accepted = 0;
    out_ready = 1'b0;
    for (int i = 0; i < 20 && accepted < 4; i++) begin
      msg_end = 1'b1; msg_id = 4'(10 + accepted);
      if (in_ready) accepted++;
      step();
    end
    msg_end = 1'b0;
    checks++; if (accepted != 4) begin errors++; $display("FAIL ovf_fill got=%0d want=4", accepted); end
    repeat (6) step();
    msg_end = 1'b1; msg_id = 4'd14;
    force dut.accept = 1'b1;
    step();
    release dut.accept;
    msg_end = 1'b0;
    step(); step(); step();
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_early got=%b want=0", overflow); end
    step();
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got=%b want=1", overflow); end
    checks++; if (dut.fifo_count !== 3'd4 || out_id !== 4'd10) begin
      errors++; $display("FAIL ovf_contents got=%0d/%0d want=4/10", dut.fifo_count, out_id);
    end
    repeat (3) step();
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%b want=1", overflow); end
    exp_q.delete();
  endtask

  task automatic test_reset_midop();
    int seen = 0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_ovf_clear got=%b want=0", overflow); end
    for (int i = 0; i < 5; i++) begin
      msg_end = (i == 0 || i == 3 || i == 4);
      msg_id  = 4'(5 + i);
      step();
    end
    msg_end = 1'b0;
    checks++; if (out_valid !== 1'b1 || dut.inflight_q !== 3'd2) begin
      errors++; $display("FAIL rst_setup got=%b/%0d want=1/2", out_valid, dut.inflight_q);
    end
    #3 rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || out_crc !== 8'h00 || out_id !== 4'h0) begin
      errors++; $display("FAIL rst_async got=%b/%h/%0d want=0/00/0", out_valid, out_crc, out_id);
    end
    checks++; if (dut.inflight_q !== 3'd0 || dut.tag_vld_q !== 4'b0) begin
      errors++; $display("FAIL rst_state got=%0d/%b want=0/0000", dut.inflight_q, dut.tag_vld_q);
    end
    step();
    rst = 1'b0;
    step();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got=%b want=1", in_ready); end
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) seen++;
      step();
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL rst_stale got=%0d want=0", seen); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_fill();
    test_full_push_pop();
    test_back_to_back();
    test_overflow();
    test_reset_midop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
